// File: rtl/modexp_engine_if.sv
// Job interface between the partner block and the modular exponentiator.
// The partner drives the operands and start; the engine returns status and result.
interface modexp_engine_if #(
    parameter int LEN   = 100,
    parameter int EXP_W = 100
);
    logic             start;
    logic [LEN-1:0]   prime_in;
    logic [LEN-1:0]   base_in;
    logic [EXP_W-1:0] exp_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [LEN-1:0]   result;

    modport master (
        output start, prime_in, base_in, exp_in,
        input  busy, done, err, result
    );

    modport slave (
        input  start, prime_in, base_in, exp_in,
        output busy, done, err, result
    );
endinterface

// File: rtl/modexp_engine.sv
// Right-to-left square-and-multiply modular exponentiator built on a bit-serial modular multiplier.
// Optional macro MODEXP_CONST_TIME_EN: run the multiply-into-R pass for every exponent bit.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; operands latched and checked on accept
// S_MUL_R | R <= R*B mod p, one multiplier bit per cycle, LEN cycles
// S_MUL_B | B <= B*B mod p, one multiplier bit per cycle, LEN cycles
// S_DONE  | one-cycle done pulse, result/err valid
module modexp_engine #(
    parameter int LEN   = 100,
    parameter int EXP_W = 100
) (
    input logic           clk,
    input logic           rst,
    modexp_engine_if.slave bus
);
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam int ACC_W = LEN + 2;

`ifdef MODEXP_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL_R = 2'd1,
        S_MUL_B = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [LEN-1:0]   p_reg;
    logic [LEN-1:0]   r_reg;
    logic [LEN-1:0]   b_reg;
    logic [EXP_W-1:0] e_reg;
    logic [EXP_W-1:0] e_shift;
    logic [IDX_W-1:0] bit_idx;
    logic [CNT_W-1:0] mul_cnt;
    logic [ACC_W-1:0] acc;
    logic [LEN-1:0]   result_reg;
    logic             err_reg;

    logic             op_bad;
    logic             mul_last;
    logic             bit_last;
    logic [LEN-1:0]   mul_x;
    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] acc_dbl;
    logic [ACC_W-1:0] acc_red;
    logic [ACC_W-1:0] acc_add;
    logic [ACC_W-1:0] acc_nxt;

    assign op_bad   = (bus.prime_in < LEN'(2)) || (bus.base_in >= bus.prime_in);
    assign mul_last = (mul_cnt == '0);
    assign bit_last = (bit_idx == IDX_W'(EXP_W - 1));
    assign e_shift  = e_reg >> 1;

    // Interleaved modular multiply step; the multiplier operand is always B.
    always_comb begin
        mul_x   = (state == S_MUL_R) ? r_reg : b_reg;
        p_ext   = {2'b00, p_reg};
        acc_dbl = {acc[ACC_W-2:0], 1'b0};
        acc_red = (acc_dbl >= p_ext) ? (acc_dbl - p_ext) : acc_dbl;
        acc_add = b_reg[mul_cnt] ? (acc_red + {2'b00, mul_x}) : acc_red;
        acc_nxt = (acc_add >= p_ext) ? (acc_add - p_ext) : acc_add;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (op_bad) begin
                        state_nxt = S_DONE;
                    end else if (CONST_TIME || bus.exp_in[0]) begin
                        state_nxt = S_MUL_R;
                    end else begin
                        state_nxt = S_MUL_B;
                    end
                end
            end
            S_MUL_R: begin
                if (mul_last) begin
                    state_nxt = S_MUL_B;
                end
            end
            S_MUL_B: begin
                if (mul_last) begin
                    if (bit_last) begin
                        state_nxt = S_DONE;
                    end else if (CONST_TIME || e_shift[0]) begin
                        state_nxt = S_MUL_R;
                    end else begin
                        state_nxt = S_MUL_B;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy   = (state != S_IDLE);
        bus.done   = (state == S_DONE);
        bus.err    = err_reg;
        bus.result = result_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_reg      <= '0;
            r_reg      <= '0;
            b_reg      <= '0;
            e_reg      <= '0;
            bit_idx    <= '0;
            mul_cnt    <= '0;
            acc        <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        p_reg      <= bus.prime_in;
                        r_reg      <= LEN'(1);
                        b_reg      <= bus.base_in;
                        e_reg      <= bus.exp_in;
                        bit_idx    <= '0;
                        mul_cnt    <= CNT_W'(LEN - 1);
                        acc        <= '0;
                        result_reg <= '0;
                        err_reg    <= op_bad;
                    end
                end
                S_MUL_R: begin
                    if (mul_last) begin
                        // In the constant-time build the product is discarded for zero bits.
                        if (e_reg[0]) begin
                            r_reg <= acc_nxt[LEN-1:0];
                        end
                        acc     <= '0;
                        mul_cnt <= CNT_W'(LEN - 1);
                    end else begin
                        acc     <= acc_nxt;
                        mul_cnt <= mul_cnt - 1'b1;
                    end
                end
                S_MUL_B: begin
                    if (mul_last) begin
                        b_reg   <= acc_nxt[LEN-1:0];
                        acc     <= '0;
                        mul_cnt <= CNT_W'(LEN - 1);
                        e_reg   <= e_shift;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_last) begin
                            result_reg <= r_reg;
                        end
                    end else begin
                        acc     <= acc_nxt;
                        mul_cnt <= mul_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
